// File: rtl/jk_excitation_driver_if.sv
// rtl/jk_excitation_driver_if.sv - pattern load, run control, flip-flop excitation and check status bundle
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic             LOAD;
  logic [AW-1:0]    LOAD_ADDR;
  logic [WIDTH-1:0] LOAD_DATA;
  logic             START;
  logic [LW-1:0]    LEN;
  logic [WIDTH-1:0] Q_OBS;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [AW-1:0]    ERR_STEP;

  modport master (
    output LOAD, LOAD_ADDR, LOAD_DATA, START, LEN, Q_OBS,
    input  J, K, BUSY, DONE, ERR, ERR_STEP
  );

  modport slave (
    input  LOAD, LOAD_ADDR, LOAD_DATA, START, LEN, Q_OBS,
    output J, K, BUSY, DONE, ERR, ERR_STEP
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - steps a JK flip-flop bank through a stored target sequence and checks Q
module jk_excitation_driver #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 8,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  jk_excitation_driver_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] pattern [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW-1:0]    exp_idx;
  logic [WIDTH-1:0] exp_state;
  logic             chk_valid;
  logic [LW-1:0]    n;
  logic [WIDTH-1:0] j_q, k_q;
  logic             busy_q, done_q, err_q;
  logic [AW-1:0]    err_step_q;

  logic [LW-1:0]    len_clamped;
  logic [LW-1:0]    idx_next;
  logic [WIDTH-1:0] pat_cur, pat_nxt;

  function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    return (TOGGLE_MODE != 0) ? (q ^ t) : (t & (q ^ t));
  endfunction

  function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
    return (TOGGLE_MODE != 0) ? (q ^ t) : (~t & (q ^ t));
  endfunction

  assign len_clamped = (bus.LEN > LW'(DEPTH)) ? LW'(DEPTH) : bus.LEN;
  assign idx_next    = LW'(idx) + LW'(1);
  assign pat_cur     = pattern[idx];
  // Wraps only when idx is the last entry, in which case the value is never used.
  assign pat_nxt     = pattern[idx_next[AW-1:0]];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
    end else if (bus.LOAD && !busy_q && (int'(bus.LOAD_ADDR) < DEPTH)) begin
      pattern[bus.LOAD_ADDR] <= bus.LOAD_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      idx        <= '0;
      exp_idx    <= '0;
      exp_state  <= '0;
      chk_valid  <= 1'b0;
      n          <= '0;
      j_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_step_q <= '0;
    end else begin
      done_q <= 1'b0;
      // Checks trail the excitation by two edges: one for the FF to switch, one to register exp.
      if (chk_valid && (bus.Q_OBS != exp_state) && !err_q) begin
        err_q      <= 1'b1;
        err_step_q <= exp_idx;
      end
      case (state)
        S_IDLE: begin
          j_q <= '0;
          k_q <= '0;
          if (bus.START && (bus.LEN != '0)) begin
            j_q        <= excite_j(bus.Q_OBS, pattern[0]);
            k_q        <= excite_k(bus.Q_OBS, pattern[0]);
            idx        <= '0;
            n          <= len_clamped;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            err_step_q <= '0;
            chk_valid  <= 1'b0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          exp_state <= pat_cur;
          exp_idx   <= idx;
          chk_valid <= 1'b1;
          if (idx_next < n) begin
            j_q <= excite_j(pat_cur, pat_nxt);
            k_q <= excite_k(pat_cur, pat_nxt);
            idx <= idx_next[AW-1:0];
          end else begin
            j_q   <= '0;
            k_q   <= '0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          chk_valid <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.J        = j_q;
  assign bus.K        = k_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.ERR_STEP = err_step_q;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - directed checks of the JK excitation driver with modelled flip-flop banks
module tb_jk_excitation_driver;
  logic CLK = 1'b0;
  logic RESET;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  jk_excitation_driver_if #(.WIDTH(4), .DEPTH(8)) b0 ();
  jk_excitation_driver_if #(.WIDTH(1), .DEPTH(8)) b1 ();

  jk_excitation_driver #(.WIDTH(4), .DEPTH(8), .TOGGLE_MODE(0)) dut0 (.CLK(CLK), .RESET(RESET), .bus(b0));
  jk_excitation_driver #(.WIDTH(1), .DEPTH(8), .TOGGLE_MODE(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(b1));

  // Flip-flop banks under test; stuck0 forces selected bits of bank 0 to 0.
  logic [3:0] q0;
  logic       q1;
  logic [3:0] stuck0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q0 <= '0;
      q1 <= 1'b0;
    end else begin
      q0 <= ((b0.J & ~q0) | (~b0.K & q0)) & ~stuck0;
      q1 <= (b1.J & ~q1) | (~b1.K & q1);
    end
  end

  assign b0.Q_OBS = q0;
  assign b1.Q_OBS = q1;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int a, input logic [3:0] d0, input logic d1, input bit both);
    b0.LOAD = 1'b1; b0.LOAD_ADDR = 3'(a); b0.LOAD_DATA = d0;
    if (both) begin b1.LOAD = 1'b1; b1.LOAD_ADDR = 3'(a); b1.LOAD_DATA = d1; end
    tick();
    b0.LOAD = 1'b0;
    b1.LOAD = 1'b0;
  endtask

  // Starts a run on bank 0 and watches a fixed 14-cycle window; inj 1 pokes LOAD/START
  // mid-run, inj 2 writes entry 0 on the very START edge.
  task automatic run0(input logic [3:0] len, input int inj, output int bc, output int dc,
                      output logic [3:0] j0, output logic [3:0] k0);
    b0.START = 1'b1; b0.LEN = len;
    if (inj == 2) begin b0.LOAD = 1'b1; b0.LOAD_ADDR = 3'd0; b0.LOAD_DATA = 4'h6; end
    tick();
    b0.START = 1'b0; b0.LOAD = 1'b0;
    j0 = b0.J; k0 = b0.K; bc = 0; dc = 0;
    for (int i = 0; i < 14; i++) begin
      bc += int'(b0.BUSY);
      dc += int'(b0.DONE);
      if (inj == 1 && i == 2) begin
        b0.LOAD = 1'b1; b0.LOAD_ADDR = 3'd0; b0.LOAD_DATA = 4'hF; b0.START = 1'b1;
      end else begin
        b0.LOAD = 1'b0; b0.START = 1'b0;
      end
      tick();
    end
  endtask

  int         bc, dc;
  logic [3:0] j0, k0;
  logic [4:0] jt0, kt0, jt1, qt1;

  initial begin
    RESET = 1'b1; stuck0 = '0;
    b0.LOAD = 0; b0.LOAD_ADDR = '0; b0.LOAD_DATA = '0; b0.START = 0; b0.LEN = '0;
    b1.LOAD = 0; b1.LOAD_ADDR = '0; b1.LOAD_DATA = '0; b1.START = 0; b1.LEN = '0;
    tick(); tick();
    chk("rst_j", 32'(b0.J), 32'h0);
    chk("rst_k", 32'(b0.K), 32'h0);
    chk("rst_busy", 32'(b0.BUSY), 32'h0);
    chk("rst_done", 32'(b0.DONE), 32'h0);
    chk("rst_err", 32'(b0.ERR), 32'h0);
    chk("rst_err_step", 32'(b0.ERR_STEP), 32'h0);
    RESET = 1'b0;
    tick();

    // Pattern 1,0,1,1: set/reset mode on bit 0 of bank 0, toggle mode on bank 1
    load(0, 4'h1, 1'b1, 1'b1);
    load(1, 4'h0, 1'b0, 1'b1);
    load(2, 4'h1, 1'b1, 1'b1);
    load(3, 4'h1, 1'b1, 1'b1);
    jt0 = 5'b00101; kt0 = 5'b00010; jt1 = 5'b00111; qt1 = 5'b11010;
    b0.START = 1'b1; b0.LEN = 4'd4; b1.START = 1'b1; b1.LEN = 4'd4;
    tick();
    b0.START = 1'b0; b1.START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sr_j%0d", i), 32'(b0.J), 32'(jt0[i]));
      chk($sformatf("sr_k%0d", i), 32'(b0.K), 32'(kt0[i]));
      chk($sformatf("sr_busy%0d", i), 32'(b0.BUSY), 32'h1);
      chk($sformatf("tg_j%0d", i), 32'(b1.J), 32'(jt1[i]));
      chk($sformatf("tg_k%0d", i), 32'(b1.K), 32'(jt1[i]));
      chk($sformatf("tg_q%0d", i), 32'(q1), 32'(qt1[i]));
      tick();
    end
    chk("sr_busy_end", 32'(b0.BUSY), 32'h0);
    chk("sr_done", 32'(b0.DONE), 32'h1);
    chk("sr_err", 32'(b0.ERR), 32'h0);
    chk("tg_done", 32'(b1.DONE), 32'h1);
    chk("tg_err", 32'(b1.ERR), 32'h0);
    tick();
    chk("sr_done_pulse", 32'(b0.DONE), 32'h0);

    // Pattern 3,5,A with bit 3 stuck at 0: first miss at step 2
    load(0, 4'h3, 1'b0, 1'b0);
    load(1, 4'h5, 1'b0, 1'b0);
    load(2, 4'hA, 1'b0, 1'b0);
    stuck0 = 4'b1000;
    run0(4'd3, 0, bc, dc, j0, k0);
    chk("stuck_busy", 32'(bc), 32'd4);
    chk("stuck_done", 32'(dc), 32'd1);
    chk("stuck_err", 32'(b0.ERR), 32'h1);
    chk("stuck_err_step", 32'(b0.ERR_STEP), 32'h2);

    // LEN=0 is ignored and leaves the sticky error alone
    run0(4'd0, 0, bc, dc, j0, k0);
    chk("len0_busy", 32'(bc), 32'd0);
    chk("len0_done", 32'(dc), 32'd0);
    chk("len0_err", 32'(b0.ERR), 32'h1);
    chk("len0_err_step", 32'(b0.ERR_STEP), 32'h2);

    // LEN=12 clamps to 8; only step 7 needs the stuck bit, so the eighth check must happen
    load(2, 4'h2, 1'b0, 1'b0);
    load(3, 4'h1, 1'b0, 1'b0);
    load(4, 4'h0, 1'b0, 1'b0);
    load(5, 4'h4, 1'b0, 1'b0);
    load(6, 4'h6, 1'b0, 1'b0);
    load(7, 4'h8, 1'b0, 1'b0);
    run0(4'd12, 0, bc, dc, j0, k0);
    chk("clamp_busy", 32'(bc), 32'd9);
    chk("clamp_done", 32'(dc), 32'd1);
    chk("clamp_err", 32'(b0.ERR), 32'h1);
    chk("clamp_err_step", 32'(b0.ERR_STEP), 32'h7);
    stuck0 = '0;

    // Asynchronous reset in the middle of a run
    b0.START = 1'b1; b0.LEN = 4'd8;
    tick();
    b0.START = 1'b0;
    tick(); tick();
    RESET = 1'b1;
    #1;
    chk("arst_j", 32'(b0.J), 32'h0);
    chk("arst_k", 32'(b0.K), 32'h0);
    chk("arst_busy", 32'(b0.BUSY), 32'h0);
    tick();
    RESET = 1'b0;
    dc = 0;
    for (int i = 0; i < 6; i++) begin
      dc += int'(b0.DONE);
      tick();
    end
    chk("arst_no_done", 32'(dc), 32'd0);
    load(0, 4'h1, 1'b0, 1'b0);
    load(1, 4'h0, 1'b0, 1'b0);
    load(2, 4'h1, 1'b0, 1'b0);
    load(3, 4'h1, 1'b0, 1'b0);
    run0(4'd4, 0, bc, dc, j0, k0);
    chk("after_rst_j0", 32'(j0), 32'h1);
    chk("after_rst_k0", 32'(k0), 32'h0);
    chk("after_rst_busy", 32'(bc), 32'd5);
    chk("after_rst_done", 32'(dc), 32'd1);
    chk("after_rst_err", 32'(b0.ERR), 32'h0);

    // LOAD and START while busy are ignored
    run0(4'd4, 1, bc, dc, j0, k0);
    chk("busy_poke_busy", 32'(bc), 32'd5);
    chk("busy_poke_done", 32'(dc), 32'd1);
    chk("busy_poke_err", 32'(b0.ERR), 32'h0);
    run0(4'd4, 0, bc, dc, j0, k0);
    chk("busy_poke_keep_j0", 32'(j0), 32'h0);
    chk("busy_poke_keep_k0", 32'(k0), 32'h0);

    // LOAD on the START edge: this run sees the old entry, the next one the new
    run0(4'd1, 2, bc, dc, j0, k0);
    chk("same_edge_old_j0", 32'(j0), 32'h0);
    chk("same_edge_old_k0", 32'(k0), 32'h0);
    chk("same_edge_busy", 32'(bc), 32'd2);
    run0(4'd1, 0, bc, dc, j0, k0);
    chk("same_edge_new_j0", 32'(j0), 32'h6);
    chk("same_edge_new_k0", 32'(k0), 32'h1);
    chk("same_edge_new_err", 32'(b0.ERR), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
